// File: rtl/rob_pkg.sv
// rob_pkg: shared widths, tag encodings and entry layout for the reorder buffer and its neighbours.
package rob_pkg;
    localparam int ROB_SIZE = 16;
    localparam int IDX_W    = 4;
    localparam int TAG_W    = 5;
    localparam int REG_W    = 5;
    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 32;
    localparam logic [TAG_W-1:0]  EMPTY_TAG  = 5'b10000;
    localparam logic [DATA_W-1:0] EMPTY_DATA = '0;
    localparam logic [REG_W-1:0]  EMPTY_REG  = '0;
    typedef struct packed {
        logic              ready;
        logic [REG_W-1:0]  rd;
        logic [DATA_W-1:0] data;
        logic              mispredict;
        logic [ADDR_W-1:0] target;
    } entry_t;
    function automatic logic [TAG_W-1:0] idx2tag(input logic [IDX_W-1:0] i);
        return TAG_W'(i);
    endfunction
endpackage

// File: rtl/rob_query.sv
// rob_query: two-port operand lookup by tag, with the CDB broadcast bypassing the stored entry.
module rob_query
    import rob_pkg::*;
(
    input  logic [TAG_W-1:0]               query_tag1,
    input  logic [TAG_W-1:0]               query_tag2,
    input  logic                           wb_valid,
    input  logic [TAG_W-1:0]               wb_tag,
    input  logic [DATA_W-1:0]              wb_data,
    input  logic [ROB_SIZE-1:0]            busy,
    input  logic [ROB_SIZE-1:0]            ready,
    input  logic [ROB_SIZE-1:0][DATA_W-1:0] data,
    output logic                           query_ready1,
    output logic                           query_ready2,
    output logic [DATA_W-1:0]              query_data1,
    output logic [DATA_W-1:0]              query_data2
);
    logic [IDX_W-1:0] i1, i2;
    logic byp1, byp2, hit1, hit2;
    // Tags with the top bit set (including EMPTY_TAG) never name a real entry.
    assign i1   = query_tag1[IDX_W-1:0];
    assign i2   = query_tag2[IDX_W-1:0];
    assign byp1 = !query_tag1[IDX_W] && wb_valid && wb_tag == query_tag1;
    assign byp2 = !query_tag2[IDX_W] && wb_valid && wb_tag == query_tag2;
    assign hit1 = !query_tag1[IDX_W] && busy[i1] && ready[i1];
    assign hit2 = !query_tag2[IDX_W] && busy[i2] && ready[i2];
    assign query_ready1 = byp1 || hit1;
    assign query_ready2 = byp2 || hit2;
    assign query_data1  = byp1 ? wb_data : hit1 ? data[i1] : EMPTY_DATA;
    assign query_data2  = byp2 ? wb_data : hit2 ? data[i2] : EMPTY_DATA;
endmodule

// File: rtl/rob.sv
// rob: reorder buffer; allocates tags, collects CDB results and retires in order,
// flushing the core when a mispredicted branch retires.
module rob
    import rob_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              issue_valid,
    input  logic [REG_W-1:0]  issue_rd,
    output logic [TAG_W-1:0]  issue_tag,
    output logic              rob_full,
    input  logic              wb_valid,
    input  logic [TAG_W-1:0]  wb_tag,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              wb_mispredict,
    input  logic [ADDR_W-1:0] wb_target,
    input  logic [TAG_W-1:0]  query_tag1,
    input  logic [TAG_W-1:0]  query_tag2,
    output logic              query_ready1,
    output logic              query_ready2,
    output logic [DATA_W-1:0] query_data1,
    output logic [DATA_W-1:0] query_data2,
    output logic              if_commit,
    output logic [REG_W-1:0]  pos_commit,
    output logic [DATA_W-1:0] data_commit,
    output logic [TAG_W-1:0]  tag_commit,
    output logic              clear,
    output logic [ADDR_W-1:0] clear_pc
);
    logic [IDX_W-1:0] head, tail, wb_idx;
    logic [IDX_W:0]   count;
    logic [ROB_SIZE-1:0] busy, ent_rdy;
    logic [ROB_SIZE-1:0][DATA_W-1:0] ent_dat;
    entry_t ent [ROB_SIZE];
    logic do_issue, do_wb, do_commit, flush;

    assign rob_full  = count == (IDX_W+1)'(ROB_SIZE);
    assign issue_tag = idx2tag(tail);
    assign wb_idx    = wb_tag[IDX_W-1:0];
    assign do_wb     = wb_valid && !wb_tag[IDX_W] && busy[wb_idx];
    // Commit looks only at registered readiness, so a same-edge writeback waits a cycle.
    assign do_commit = busy[head] && ent[head].ready;
    assign flush     = do_commit && ent[head].mispredict;
    assign do_issue  = issue_valid && !rob_full && !flush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            busy        <= '0;
            if_commit   <= 1'b0;
            clear       <= 1'b0;
            pos_commit  <= EMPTY_REG;
            data_commit <= EMPTY_DATA;
            tag_commit  <= EMPTY_TAG;
            clear_pc    <= '0;
        end else if (!rdy) begin
            if_commit <= 1'b0;
            clear     <= 1'b0;
        end else begin
            if_commit <= do_commit && ent[head].rd != EMPTY_REG;
            clear     <= flush;
            if (do_commit) begin
                pos_commit  <= ent[head].rd;
                data_commit <= ent[head].data;
                tag_commit  <= idx2tag(head);
            end
            if (flush) begin
                clear_pc <= ent[head].target;
                busy     <= '0;
                head     <= '0;
                tail     <= '0;
                count    <= '0;
            end else begin
                if (do_issue) begin
                    busy[tail] <= 1'b1;
                    tail       <= tail + 1'b1;
                end
                if (do_commit) begin
                    busy[head] <= 1'b0;
                    head       <= head + 1'b1;
                end
                count <= count + (IDX_W+1)'(do_issue) - (IDX_W+1)'(do_commit);
            end
        end
    end

    // Payload needs no reset: busy gates every use of it.
    always_ff @(posedge clk) begin
        if (rdy) begin
            if (do_wb) begin
                ent[wb_idx].ready      <= 1'b1;
                ent[wb_idx].data       <= wb_data;
                ent[wb_idx].mispredict <= wb_mispredict;
                ent[wb_idx].target     <= wb_target;
            end
            if (do_issue) begin
                ent[tail].ready      <= 1'b0;
                ent[tail].rd         <= issue_rd;
                ent[tail].mispredict <= 1'b0;
            end
        end
    end

    for (genvar i = 0; i < ROB_SIZE; i++) begin : g_vec
        assign ent_rdy[i] = ent[i].ready;
        assign ent_dat[i] = ent[i].data;
    end

    rob_query u_query (
        .query_tag1   (query_tag1),
        .query_tag2   (query_tag2),
        .wb_valid     (wb_valid),
        .wb_tag       (wb_tag),
        .wb_data      (wb_data),
        .busy         (busy),
        .ready        (ent_rdy),
        .data         (ent_dat),
        .query_ready1 (query_ready1),
        .query_ready2 (query_ready2),
        .query_data1  (query_data1),
        .query_data2  (query_data2)
    );
endmodule
